// File: rtl/regfile_master_pkg.sv
// Shared definitions for the register-file command master: op codes, FSM states, default sizes.
// The optional write-acknowledge (RFM_WRITE_ACK_EN) is handled in regfile_master.sv.
package regfile_master_pkg;

    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_DUMP  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DUMP,
        ST_RESP
    } state_e;

endpackage

// File: rtl/regfile_master_if.sv
// Command and response channels of the register-file master, both valid/ready.
interface regfile_master_if #(
    parameter int ADDR_W = regfile_master_pkg::DEF_ADDR_W,
    parameter int DATA_W = regfile_master_pkg::DEF_DATA_W
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr1;
    logic [ADDR_W-1:0] cmd_addr2;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [ADDR_W-1:0] rsp_addr;
    logic [DATA_W-1:0] rsp_data1;
    logic [DATA_W-1:0] rsp_data2;
    logic              rsp_last;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr1, cmd_addr2, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_addr, rsp_data1, rsp_data2, rsp_last
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr1, cmd_addr2, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_addr, rsp_data1, rsp_data2, rsp_last
    );

endinterface

// File: rtl/regfile_master_dump_counter.sv
// Beat counter for the dump sweep: clear on command accept, increment per consumed beat.
module rfm_dump_counter #(
    parameter int K_W  = 4,
    parameter int LAST = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           inc,
    output logic [K_W-1:0] k,
    output logic           last
);

    logic [K_W-1:0] k_q, k_d;

    always_comb begin
        k_d = k_q;
        if (clr) begin
            k_d = '0;
        end else if (inc && !last) begin
            k_d = k_q + K_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q <= '0;
        end else begin
            k_q <= k_d;
        end
    end

    assign k    = k_q;
    assign last = (k_q == K_W'(LAST));

endmodule

// File: rtl/regfile_master.sv
// Command-driven initiator for a 2R/1W register file; every rf_* and response output is a flop.
// Define RFM_WRITE_ACK_EN to return an acknowledge beat after each write.
module regfile_master
    import regfile_master_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic              clk,
    input  logic              rst,
    regfile_master_if.master  bus,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [ADDR_W-1:0] rf_raddr1,
    output logic [ADDR_W-1:0] rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2
);

    localparam int HALF = NUM_REGS / 2;
    localparam int K_W  = (HALF > 1) ? $clog2(HALF) : 1;

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic              phase_q, phase_d;
    logic [ADDR_W-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
    logic [DATA_W-1:0] rsp_data1_q, rsp_data1_d, rsp_data2_q, rsp_data2_d;
    logic              rsp_last_q, rsp_last_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic [ADDR_W-1:0] rf_raddr1_q, rf_raddr1_d, rf_raddr2_q, rf_raddr2_d;

    logic              cnt_clr, cnt_inc, cnt_last;
    logic [K_W-1:0]    cnt_k, cnt_k_inc;
    logic [ADDR_W-1:0] dump_a1, dump_a2, next_a1, next_a2;

    rfm_dump_counter #(.K_W(K_W), .LAST(HALF - 1)) u_dump_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .k    (cnt_k),
        .last (cnt_last)
    );

    assign cnt_k_inc = cnt_k + K_W'(1);
    assign dump_a1   = ADDR_W'({cnt_k, 1'b0});
    assign dump_a2   = ADDR_W'({cnt_k, 1'b1});
    assign next_a1   = ADDR_W'({cnt_k_inc, 1'b0});
    assign next_a2   = ADDR_W'({cnt_k_inc, 1'b1});

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        phase_d     = phase_q;
        addr1_d     = addr1_q;
        addr2_d     = addr2_q;
        wdata_d     = wdata_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_data1_d = rsp_data1_q;
        rsp_data2_d = rsp_data2_q;
        rsp_last_d  = rsp_last_q;
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        rf_raddr1_d = rf_raddr1_q;
        rf_raddr2_d = rf_raddr2_q;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (bus.cmd_valid && cmd_ready_q) begin
                    op_d    = op_e'(bus.cmd_op);
                    addr1_d = bus.cmd_addr1;
                    addr2_d = bus.cmd_addr2;
                    wdata_d = bus.cmd_wdata;
                    phase_d = 1'b0;
                    cnt_clr = 1'b1;
                    case (op_e'(bus.cmd_op))
                        OP_WRITE: begin state_d = ST_WRITE; cmd_ready_d = 1'b0; end
                        OP_READ:  begin state_d = ST_READ;  cmd_ready_d = 1'b0; end
                        OP_DUMP:  begin state_d = ST_DUMP;  cmd_ready_d = 1'b0; end
                        default:  ;
                    endcase
                end
            end
            ST_WRITE: begin
                // r0 is hard-wired zero in the register file, so never strobe it.
                rf_we_d    = (addr1_q != '0);
                rf_waddr_d = addr1_q;
                rf_wdata_d = wdata_q;
`ifdef RFM_WRITE_ACK_EN
                rsp_valid_d = 1'b1;
                rsp_addr_d  = addr1_q;
                rsp_data1_d = (addr1_q == '0) ? '0 : wdata_q;
                rsp_data2_d = '0;
                rsp_last_d  = 1'b1;
                state_d     = ST_RESP;
`else
                state_d     = ST_IDLE;
`endif
            end
            ST_READ, ST_DUMP: begin
                // Phase 0 registers the read addresses; phase 1 captures the data they select.
                if (!phase_q) begin
                    rf_raddr1_d = (state_q == ST_READ) ? addr1_q : dump_a1;
                    rf_raddr2_d = (state_q == ST_READ) ? addr2_q : dump_a2;
                    phase_d     = 1'b1;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_addr_d  = rf_raddr1_q;
                    rsp_data1_d = (rf_raddr1_q == '0) ? '0 : rf_rdata1;
                    rsp_data2_d = (rf_raddr2_q == '0) ? '0 : rf_rdata2;
                    rsp_last_d  = (state_q == ST_READ) || cnt_last;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (op_q == OP_DUMP && !cnt_last) begin
                        // Present the next pair now so the following cycle can capture directly.
                        cnt_inc     = 1'b1;
                        rf_raddr1_d = next_a1;
                        rf_raddr2_d = next_a2;
                        phase_d     = 1'b1;
                        state_d     = ST_DUMP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_WRITE;
            phase_q     <= 1'b0;
            addr1_q     <= '0;
            addr2_q     <= '0;
            wdata_q     <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_data1_q <= '0;
            rsp_data2_q <= '0;
            rsp_last_q  <= 1'b0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            rf_raddr1_q <= '0;
            rf_raddr2_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            phase_q     <= phase_d;
            addr1_q     <= addr1_d;
            addr2_q     <= addr2_d;
            wdata_q     <= wdata_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_data1_q <= rsp_data1_d;
            rsp_data2_q <= rsp_data2_d;
            rsp_last_q  <= rsp_last_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            rf_raddr1_q <= rf_raddr1_d;
            rf_raddr2_q <= rf_raddr2_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_addr  = rsp_addr_q;
    assign bus.rsp_data1 = rsp_data1_q;
    assign bus.rsp_data2 = rsp_data2_q;
    assign bus.rsp_last  = rsp_last_q;
    assign rf_we         = rf_we_q;
    assign rf_waddr      = rf_waddr_q;
    assign rf_wdata      = rf_wdata_q;
    assign rf_raddr1     = rf_raddr1_q;
    assign rf_raddr2     = rf_raddr2_q;

endmodule

// File: tb/tb_regfile_master.sv
// Directed bench for regfile_master with a register-file model and a response scoreboard.
module tb_regfile_master;
    import regfile_master_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_master_if bus ();

    logic        rf_we;
    logic [4:0]  rf_waddr, rf_raddr1, rf_raddr2;
    logic [31:0] rf_wdata, rf_rdata1, rf_rdata2;

    regfile_master dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .rf_raddr1 (rf_raddr1),
        .rf_raddr2 (rf_raddr2),
        .rf_rdata1 (rf_rdata1),
        .rf_rdata2 (rf_rdata2)
    );

    // Register file: falling-edge write, combinational read; r0 storage holds junk the master must mask.
    logic [31:0] rf_mem [32];
    always @(negedge clk) if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
    assign rf_rdata1 = (rf_raddr1 == 5'd0) ? 32'hBAD0_BAD0 : rf_mem[rf_raddr1];
    assign rf_rdata2 = (rf_raddr2 == 5'd0) ? 32'hBAD0_BAD0 : rf_mem[rf_raddr2];

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        last;
    } exp_t;

    exp_t        q[$];
    logic [31:0] shadow [32];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          accept_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [4:0] a, input logic [31:0] d1, input logic [31:0] d2, input logic l);
        exp_t e;
        e.addr = a; e.d1 = d1; e.d2 = d2; e.last = l;
        q.push_back(e);
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [4:0] a1, input logic [4:0] a2, input logic [31:0] wd);
        @(negedge clk);
        bus.cmd_op    = op;
        bus.cmd_addr1 = a1;
        bus.cmd_addr2 = a2;
        bus.cmd_wdata = wd;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 64 && bus.cmd_ready !== 1'b1; i++) @(negedge clk);
        check("cmd_accept", 64'(bus.cmd_ready), 64'(1));
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        accept_cyc    = cyc;
        $display("cmd op=%0d a1=%0d a2=%0d wdata=%h accepted at cycle %0d", op, a1, a2, wd, accept_cyc);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 100 && bus.rsp_valid !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        check(tag, 64'(bus.rsp_valid), 64'(1));
    endtask

    task automatic collect(input int n, input int stall_at, input int stall_len, input bit timed);
        exp_t e;
        for (int b = 0; b < n; b++) begin
            wait_valid("rsp_wait");
            if (bus.rsp_valid !== 1'b1) return;
            check("sb_nonempty", 64'(q.size() > 0), 64'(1));
            if (q.size() == 0) return;
            e = q.pop_front();
            $display("rsp beat %0d addr=%0d d1=%h d2=%h last=%0b cycle %0d",
                     b, bus.rsp_addr, bus.rsp_data1, bus.rsp_data2, bus.rsp_last, cyc);
            if (timed) check("beat_time", 64'(cyc), 64'(accept_cyc + 2 + 2 * b));
            check("rsp_addr",  64'(bus.rsp_addr),  64'(e.addr));
            check("rsp_data1", 64'(bus.rsp_data1), 64'(e.d1));
            check("rsp_data2", 64'(bus.rsp_data2), 64'(e.d2));
            check("rsp_last",  64'(bus.rsp_last),  64'(e.last));
            if (b == stall_at) begin
                bus.rsp_ready = 1'b0;
                repeat (stall_len) begin
                    @(posedge clk);
                    #1;
                    check("stall_valid", 64'(bus.rsp_valid), 64'(1));
                    check("stall_addr",  64'(bus.rsp_addr),  64'(e.addr));
                    check("stall_data1", 64'(bus.rsp_data1), 64'(e.d1));
                    check("stall_data2", 64'(bus.rsp_data2), 64'(e.d2));
                    check("stall_cmd_ready", 64'(bus.cmd_ready), 64'(0));
                end
                bus.rsp_ready = 1'b1;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
`ifdef RFM_WRITE_ACK_EN
        push_exp(a, (a == 5'd0) ? 32'd0 : d, 32'd0, 1'b1);
`endif
        send_cmd(OP_WRITE, a, 5'd0, d);
        if (a != 5'd0) shadow[a] = d;
        check("we_before", 64'(rf_we), 64'(0));
        @(posedge clk);
        #1;
        check("we_pulse", 64'(rf_we), 64'(a != 5'd0));
        check("waddr", 64'(rf_waddr), 64'(a));
        check("wdata", 64'(rf_wdata), 64'(d));
`ifdef RFM_WRITE_ACK_EN
        check("ack_cmd_ready", 64'(bus.cmd_ready), 64'(0));
        collect(1, -1, 0, 1'b0);
`else
        @(posedge clk);
        #1;
        check("we_after", 64'(rf_we), 64'(0));
        check("ready_after_write", 64'(bus.cmd_ready), 64'(1));
        check("no_write_rsp", 64'(bus.rsp_valid), 64'(0));
`endif
    endtask

    task automatic do_read(input logic [4:0] a1, input logic [4:0] a2);
        push_exp(a1, (a1 == 5'd0) ? 32'd0 : shadow[a1], (a2 == 5'd0) ? 32'd0 : shadow[a2], 1'b1);
        send_cmd(OP_READ, a1, a2, 32'd0);
        @(posedge clk);
        #1;
        check("read_not_early", 64'(bus.rsp_valid), 64'(0));
        collect(1, -1, 0, 1'b1);
        check("sb_empty", 64'(q.size()), 64'(0));
    endtask

    task automatic do_dump(input int stall_at, input int stall_len, input int abort_at, input bit timed);
        for (int k = 0; k < 16; k++)
            push_exp(5'(2 * k), (k == 0) ? 32'd0 : shadow[2 * k], shadow[2 * k + 1], k == 15);
        send_cmd(OP_DUMP, 5'd0, 5'd0, 32'd0);
        if (abort_at < 0) begin
            collect(16, stall_at, stall_len, timed);
            check("sb_empty", 64'(q.size()), 64'(0));
        end else begin
            collect(abort_at, -1, 0, 1'b0);
            wait_valid("abort_beat");
            rst = 1'b1;
            #1;
            $display("reset asserted during dump beat %0d at cycle %0d", abort_at, cyc);
            check("abort_rsp_valid", 64'(bus.rsp_valid), 64'(0));
            check("abort_cmd_ready", 64'(bus.cmd_ready), 64'(0));
            check("abort_rsp_addr",  64'(bus.rsp_addr),  64'(0));
            check("abort_rsp_data1", 64'(bus.rsp_data1), 64'(0));
            check("abort_rsp_data2", 64'(bus.rsp_data2), 64'(0));
            check("abort_rsp_last",  64'(bus.rsp_last),  64'(0));
            check("abort_raddr1",    64'(rf_raddr1),     64'(0));
            check("abort_raddr2",    64'(rf_raddr2),     64'(0));
            check("abort_we",        64'(rf_we),         64'(0));
            q.delete();
            @(negedge clk);
            rst = 1'b0;
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_addr1 = 5'd0;
        bus.cmd_addr2 = 5'd0;
        bus.cmd_wdata = 32'd0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 32; i++) shadow[i] = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'(0));
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("rst_rsp_data1", 64'(bus.rsp_data1), 64'(0));
        check("rst_rf_we",     64'(rf_we),         64'(0));
        check("rst_rf_raddr1", 64'(rf_raddr1),     64'(0));
        check("rst_rf_wdata",  64'(rf_wdata),      64'(0));
        rst = 1'b0;

        do_write(5'd5, 32'hDEAD_BEEF);
        do_read(5'd5, 5'd0);
        do_write(5'd0, 32'h1234_5678);
        do_read(5'd0, 5'd0);
        do_write(5'd7, 32'hCAFE_F00D);
        do_read(5'd7, 5'd5);

        send_cmd(OP_RSVD, 5'd3, 5'd4, 32'h0);
        check("rsvd_ready", 64'(bus.cmd_ready), 64'(1));
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rsvd_no_rsp", 64'(bus.rsp_valid), 64'(0));
        end

        for (int i = 1; i < 32; i++) do_write(5'(i), 32'h100 + 32'(i));
        do_dump(-1, 0, -1, 1'b1);
        do_dump(3, 10, -1, 1'b0);
        do_dump(-1, 0, 7, 1'b0);

        do_read(5'd5, 5'd31);
        do_read(5'd30, 5'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
